// File: rtl/bias_fetch_ctrl.sv
// bias_fetch_ctrl: shares the registered bias ROM port between a sequential
// stream engine (valid/ready output, 2-entry FIFO) and a random-access read
// port. Optional macro BIAS_CTRL_RANGE_CHECK_EN enables out-of-range
// checking of random read addresses.
module bias_fetch_ctrl #(
  parameter int NUM_BIASES = 10,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bias_valid_o,
  input  logic              bias_ready_i,
  output logic [DATA_W-1:0] bias_data_o,
  output logic [ADDR_W-1:0] bias_idx_o,
  output logic              bias_last_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_err_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BIASES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [ADDR_W-1:0] cons_cnt_q, cons_cnt_d;
  logic              prio_rd_q, prio_rd_d;   // 1: random port has priority

  // In-flight ROM read tag
  logic              infl_vld_q;
  logic              infl_rd_q;
  logic [ADDR_W-1:0] infl_idx_q;
  logic              infl_err_q;

  // Output FIFO
  logic [DATA_W-1:0] fdata_q [2];
  logic [ADDR_W-1:0] fidx_q  [2];
  logic              flast_q [2];
  logic              wptr_q, rptr_q;
  logic [1:0]        cnt_q;

  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              pop, push, strm_elig, strm_issue, rd_oor;
  logic [1:0]        occ;

`ifdef BIAS_CTRL_RANGE_CHECK_EN
  assign rd_oor = ({1'b0, rd_addr_i} >= (ADDR_W+1)'(NUM_BIASES));
`else
  assign rd_oor = 1'b0;
`endif

  assign pop  = (cnt_q != 2'd0) && bias_ready_i;
  assign push = infl_vld_q && !infl_rd_q;

  // Occupancy counted after this cycle's pop so a draining FIFO can still
  // issue every cycle; the next cycle's count plus new in-flight stays <= 2.
  assign occ = cnt_q - {1'b0, pop} + {1'b0, push};

  assign busy_o       = (state_q != IDLE);
  assign bias_valid_o = (cnt_q != 2'd0);
  assign bias_data_o  = fdata_q[rptr_q];
  assign bias_idx_o   = fidx_q[rptr_q];
  assign bias_last_o  = flast_q[rptr_q];

  assign rd_valid_o = infl_vld_q && infl_rd_q;
  assign rd_err_o   = rd_valid_o && infl_err_q;
  // ROM data is only valid in the return cycle, so the output muxes it in
  // directly and the register holds it afterwards.
  assign rd_data_o  = rd_valid_o ? (infl_err_q ? '0 : rom_data_i) : rd_data_q;

  // Round-robin arbitration of the single ROM slot
  always_comb begin
    strm_elig  = (state_q == RUN) && (occ < 2'd2);
    strm_issue = 1'b0;
    rd_gnt_o   = 1'b0;
    prio_rd_d  = prio_rd_q;
    if (strm_elig && rd_req_i) begin
      rd_gnt_o   = prio_rd_q;
      strm_issue = !prio_rd_q;
    end else begin
      rd_gnt_o   = rd_req_i;
      strm_issue = strm_elig;
    end
    if (strm_issue) prio_rd_d = 1'b1;
    if (rd_gnt_o)   prio_rd_d = 1'b0;

    rom_addr_o = rom_addr_q;
    if (strm_issue)              rom_addr_o = iss_cnt_q;
    else if (rd_gnt_o && !rd_oor) rom_addr_o = rd_addr_i;
  end

  // Stream FSM next-state, counters and done pulse
  always_comb begin
    state_d    = state_q;
    iss_cnt_d  = iss_cnt_q;
    cons_cnt_d = cons_cnt_q;
    done_o     = 1'b0;
    if (state_q != IDLE && pop) cons_cnt_d = cons_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          iss_cnt_d  = '0;
          cons_cnt_d = '0;
        end
      end
      RUN: begin
        if (strm_issue) begin
          iss_cnt_d = iss_cnt_q + 1'b1;
          if (iss_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && cons_cnt_q == LAST_IDX) begin
          state_d = IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer, in-flight tag and held read data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      iss_cnt_q  <= '0;
      cons_cnt_q <= '0;
      prio_rd_q  <= 1'b0;
      infl_vld_q <= 1'b0;
      infl_rd_q  <= 1'b0;
      infl_idx_q <= '0;
      infl_err_q <= 1'b0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      cons_cnt_q <= cons_cnt_d;
      prio_rd_q  <= prio_rd_d;
      infl_vld_q <= strm_issue || rd_gnt_o;
      infl_rd_q  <= rd_gnt_o;
      infl_idx_q <= iss_cnt_q;
      infl_err_q <= rd_gnt_o && rd_oor;
      rom_addr_q <= rom_addr_o;
      rd_data_q  <= rd_data_o;
    end
  end

  // Two-entry output FIFO capturing stream ROM returns
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        fidx_q[i]  <= '0;
        flast_q[i] <= 1'b0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        fdata_q[wptr_q] <= rom_data_i;
        fidx_q[wptr_q]  <= infl_idx_q;
        flast_q[wptr_q] <= (infl_idx_q == LAST_IDX);
        wptr_q          <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
